// File: rtl/output_acc_controller.sv
// Sequences the output shifter/accumulator register: per tile, clear/capture each K-tile, fold it into acc, then drain the row.
// Latency: start -> CLR next cycle, first load_en-eligible cycle 2 clk after start; drain takes ARRAY_HEIGHT accepted words.
// Backpressure: col_valid gaps stall LOAD, out_ready low stalls DRAIN; beat holds, nothing lost or duplicated.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num_k_tiles  tile request (sampled only in IDLE); 0 K-tiles is treated as 1
//   col_valid           partial-sum beat present from the array
//   out_ready           downstream accepts a drained word
//   load_en, load_clear, acc_enable, acc_clear, out_en   control pins of the output register
//   busy, done, k_cnt, err_overrun                       status
//   stall_cnt           only when OUT_ACC_CTRL_PERF_EN is defined: LOAD/DRAIN stall cycles
//
// Optional feature macro: OUT_ACC_CTRL_PERF_EN (adds stall_cnt).

module output_acc_controller #(
    parameter int ARRAY_HEIGHT = 8,
    parameter int KT_W         = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KT_W-1:0] num_k_tiles,
    input  logic            col_valid,
    input  logic            out_ready,
    output logic            load_en,
    output logic            load_clear,
    output logic            acc_enable,
    output logic            acc_clear,
    output logic            out_en,
    output logic            busy,
    output logic            done,
    output logic [KT_W-1:0] k_cnt,
    output logic            err_overrun
`ifdef OUT_ACC_CTRL_PERF_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int BW = (ARRAY_HEIGHT > 2) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(ARRAY_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_ACC   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat;
    logic [KT_W-1:0] kt;
    logic            start_acc;
    logic            more_k;

    assign start_acc = (state == S_IDLE) && start;
    // Compare one bit wider so k_cnt+1 cannot wrap when kt is all-ones.
    assign more_k    = ({1'b0, k_cnt} + {{KT_W{1'b0}}, 1'b1}) < {1'b0, kt};

    // Strobes are pure decodes of the state register; only load_en and
    // out_en additionally follow their handshake inputs in the same cycle.
    assign load_clear = (state == S_CLR);
    assign acc_clear  = (state == S_CLR) && (k_cnt == '0);
    assign load_en    = (state == S_LOAD) && col_valid;
    assign acc_enable = (state == S_ACC);
    assign out_en     = (state == S_DRAIN) && out_ready;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            beat        <= '0;
            kt          <= '0;
            k_cnt       <= '0;
            err_overrun <= 1'b0;
        end else begin
            // A new tile clears the sticky error; otherwise any beat offered
            // while we are not capturing is flagged.
            if (start_acc)
                err_overrun <= 1'b0;
            else if (col_valid && (state != S_LOAD))
                err_overrun <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        kt    <= (num_k_tiles == '0) ? KT_W'(1) : num_k_tiles;
                        k_cnt <= '0;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    beat  <= '0;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    if (col_valid) begin
                        if (beat == LAST_BEAT)
                            state <= S_ACC;
                        else
                            beat <= beat + 1'b1;
                    end
                end
                S_ACC: begin
                    if (more_k) begin
                        k_cnt <= k_cnt + 1'b1;
                        state <= S_CLR;
                    end else begin
                        beat  <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (beat == LAST_BEAT)
                            state <= S_DONE;
                        else
                            beat <= beat + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OUT_ACC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (((state == S_DRAIN) && !out_ready) ||
                     ((state == S_LOAD) && !col_valid)) begin
            if (stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_output_acc_controller.sv
// Bench for output_acc_controller with ARRAY_HEIGHT=4.
// Reference model: each accepted tile expands into a queue of expected phases
// (clear, load beat, fold, drain word, done) that is consumed cycle by cycle.
module tb_output_acc_controller;

    localparam int AH   = 4;
    localparam int KT_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [KT_W-1:0] num_k_tiles;
    logic            col_valid;
    logic            out_ready;
    logic            load_en, load_clear, acc_enable, acc_clear, out_en, busy, done;
    logic [KT_W-1:0] k_cnt;
    logic            err_overrun;
`ifdef OUT_ACC_CTRL_PERF_EN
    logic [15:0]     stall_cnt;
`endif

    output_acc_controller #(.ARRAY_HEIGHT(AH), .KT_W(KT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_k_tiles (num_k_tiles),
        .col_valid   (col_valid),
        .out_ready   (out_ready),
        .load_en     (load_en),
        .load_clear  (load_clear),
        .acc_enable  (acc_enable),
        .acc_clear   (acc_clear),
        .out_en      (out_en),
        .busy        (busy),
        .done        (done),
        .k_cnt       (k_cnt),
        .err_overrun (err_overrun)
`ifdef OUT_ACC_CTRL_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef enum {P_CLR, P_LOAD, P_ACC, P_DRAIN, P_DONE} phase_t;
    typedef struct {
        phase_t ph;
        int     k;
    } item_t;

    item_t q[$];
    int    last_k;
    logic  exp_err;
    int    exp_stall;
    int    checks = 0;
    int    errors = 0;
    int    acc_pulses, done_pulses, out_words;

    // Build the full phase list for one tile from the rules.
    task automatic model_start(input int nk);
        int kt;
        kt = (nk == 0) ? 1 : nk;
        for (int k = 0; k < kt; k++) begin
            q.push_back('{P_CLR, k});
            for (int b = 0; b < AH; b++) q.push_back('{P_LOAD, k});
            q.push_back('{P_ACC, k});
        end
        for (int b = 0; b < AH; b++) q.push_back('{P_DRAIN, kt - 1});
        q.push_back('{P_DONE, kt - 1});
        last_k    = 0;
        exp_err   = 1'b0;
        exp_stall = 0;
    endtask

    task automatic model_reset();
        q.delete();
        last_k    = 0;
        exp_err   = 1'b0;
        exp_stall = 0;
    endtask

    function automatic logic [6:0] obs_vec();
        return {load_en, load_clear, acc_enable, acc_clear, out_en, busy, done};
    endfunction

    // Compare current outputs to the model head, then let the model take the clock edge.
    task automatic check_and_advance(input string tag);
        logic [6:0] exp_v;
        int         exp_k;
        logic       in_load, consumed;
        item_t      h;
        exp_v   = '0;
        exp_k   = last_k;
        in_load = 1'b0;
        consumed = 1'b0;
        if (q.size() > 0) begin
            h     = q[0];
            exp_k = h.k;
            exp_v[1] = 1'b1;
            case (h.ph)
                P_CLR:   begin exp_v[5] = 1'b1; exp_v[3] = (h.k == 0); consumed = 1'b1; end
                P_LOAD:  begin exp_v[6] = col_valid; in_load = 1'b1; consumed = col_valid; end
                P_ACC:   begin exp_v[4] = 1'b1; consumed = 1'b1; end
                P_DRAIN: begin exp_v[2] = out_ready; consumed = out_ready; end
                default: begin exp_v[0] = 1'b1; consumed = 1'b1; end
            endcase
        end
        checks++;
        assert (obs_vec() === exp_v) else begin
            errors++;
            $error("FAIL %s strobes: got %b expected %b", tag, obs_vec(), exp_v);
        end
        checks++;
        assert (k_cnt === KT_W'(exp_k)) else begin
            errors++;
            $error("FAIL %s k_cnt: got %0d expected %0d", tag, k_cnt, exp_k);
        end
        checks++;
        assert (err_overrun === exp_err) else begin
            errors++;
            $error("FAIL %s err_overrun: got %b expected %b", tag, err_overrun, exp_err);
        end
`ifdef OUT_ACC_CTRL_PERF_EN
        checks++;
        assert (stall_cnt === 16'(exp_stall)) else begin
            errors++;
            $error("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, exp_stall);
        end
`endif
        if (acc_enable) acc_pulses++;
        if (done) done_pulses++;
        if (out_en) out_words++;
        // Model state update for the coming edge.
        if (q.size() == 0 && start) begin
            model_start(int'(num_k_tiles));
        end else begin
            if (col_valid && !in_load) exp_err = 1'b1;
            if (q.size() > 0) begin
                if ((q[0].ph == P_LOAD && !col_valid) || (q[0].ph == P_DRAIN && !out_ready))
                    if (exp_stall < 16'hFFFF) exp_stall++;
                if (consumed) begin
                    last_k = q[0].k;
                    void'(q.pop_front());
                end
            end
        end
    endtask

    task automatic cycle(input logic st, input int nk, input logic cv, input logic rd, input string tag);
        @(negedge clk);
        start       = st;
        num_k_tiles = KT_W'(nk);
        col_valid   = cv;
        out_ready   = rd;
        #1;
        check_and_advance(tag);
    endtask

    function automatic logic head_is(input phase_t p);
        return (q.size() > 0) && (q[0].ph == p);
    endfunction

    // Start a tile and run it to completion with random handshakes.
    task automatic run_tile(input int nk, input int cv_pct, input int rd_pct, input string tag);
        int n;
        cycle(1'b1, nk, 1'b0, 1'b0, tag);
        n = 0;
        while (q.size() > 0 && n < 400) begin
            cycle(1'b0, 0, ($urandom_range(0, 99) < cv_pct), ($urandom_range(0, 99) < rd_pct), tag);
            n++;
        end
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL %s timeout: %0d phases left, expected 0", tag, q.size());
        end
        model_reset_queue_only();
    endtask

    task automatic model_reset_queue_only();
        q.delete();
    endtask

    task automatic check_counts(input string tag, input int acc_e, input int done_e, input int out_e);
        checks++;
        assert (acc_pulses == acc_e && done_pulses == done_e && out_words == out_e) else begin
            errors++;
            $error("FAIL %s counts: got acc=%0d done=%0d out=%0d expected acc=%0d done=%0d out=%0d",
                   tag, acc_pulses, done_pulses, out_words, acc_e, done_e, out_e);
        end
        acc_pulses = 0; done_pulses = 0; out_words = 0;
    endtask

    initial begin
        logic [6:0] pat;
        int         pidx, n;
        rst_n = 1'b0; start = 1'b0; num_k_tiles = '0; col_valid = 1'b0; out_ready = 1'b0;
        acc_pulses = 0; done_pulses = 0; out_words = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        assert ({obs_vec(), k_cnt, err_overrun} === '0) else begin
            errors++;
            $error("FAIL reset_state: got %b expected 0", {obs_vec(), k_cnt, err_overrun});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 0, 1'b0, 1'b0, "idle");

        // 1: single K-tile, free-flowing handshakes.
        run_tile(1, 100, 100, "t1_single");
        check_counts("t1", 1, 1, AH);

        // 2: three K-tiles.
        run_tile(3, 100, 100, "t2_three_k");
        check_counts("t2", 3, 1, AH);

        // 3: drain under a fixed out_ready pattern.
        pat = 7'b1011001;   // applied LSB first: 1,0,0,1,1,0,1
        pidx = 0;
        cycle(1'b1, 1, 1'b0, 1'b0, "t3_start");
        n = 0;
        while (q.size() > 0 && n < 100) begin
            if (head_is(P_DRAIN)) begin
                cycle(1'b0, 0, 1'b0, pat[pidx % 7], "t3_drain");
                pidx++;
            end else begin
                cycle(1'b0, 0, head_is(P_LOAD), 1'b0, "t3_load");
            end
            n++;
        end
        check_counts("t3", 1, 1, AH);

        // 4: start pulsed mid-LOAD is ignored; col_valid in DRAIN sets the error.
        cycle(1'b1, 1, 1'b0, 1'b0, "t4_start");
        cycle(1'b0, 0, 1'b0, 1'b0, "t4_clr");
        cycle(1'b0, 0, 1'b1, 1'b0, "t4_load");
        cycle(1'b1, 5, 1'b1, 1'b0, "t4_restart");
        n = 0;
        while (q.size() > 0 && n < 100) begin
            cycle(1'b0, 0, 1'b1, 1'b1, "t4_run");
            n++;
        end
        check_counts("t4", 1, 1, AH);
        cycle(1'b0, 0, 1'b0, 1'b0, "t4_err_sticky");
        run_tile(1, 100, 100, "t4_err_cleared");
        check_counts("t4b", 1, 1, AH);

        // 5: asynchronous reset during drain after two accepted words.
        cycle(1'b1, 1, 1'b0, 1'b0, "t5_start");
        n = 0;
        while (!(head_is(P_DRAIN) && q.size() == AH - 1) && q.size() > 0 && n < 100) begin
            cycle(1'b0, 0, head_is(P_LOAD), 1'b1, "t5_run");
            n++;
        end
        @(negedge clk);
        col_valid = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert ({obs_vec(), k_cnt, err_overrun} === '0) else begin
            errors++;
            $error("FAIL t5_async_reset: got %b expected 0", {obs_vec(), k_cnt, err_overrun});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        acc_pulses = 0; done_pulses = 0; out_words = 0;
        run_tile(2, 80, 70, "t5_after_reset");
        check_counts("t5", 2, 1, AH);

        // 6: zero K-tiles behaves as one; stalls are counted.
        run_tile(0, 70, 60, "t6_zero_k");
        check_counts("t6", 1, 1, AH);

        // Randomized tiles with stray starts and stray col_valid.
        for (int t = 0; t < 25; t++) begin
            int nk;
            nk = $urandom_range(0, 4);
            cycle(1'b1, nk, 1'b0, 1'b0, "rnd_start");
            n = 0;
            while (q.size() > 0 && n < 400) begin
                cycle(($urandom_range(0, 9) == 0), $urandom_range(0, 7),
                      ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 60), "rnd_run");
                n++;
            end
            checks++;
            assert (q.size() == 0) else begin
                errors++;
                $error("FAIL rnd_timeout: %0d phases left, expected 0", q.size());
            end
            q.delete();
            check_counts("rnd", (nk == 0) ? 1 : nk, 1, AH);
            repeat ($urandom_range(0, 2)) cycle(1'b0, 0, ($urandom_range(0, 3) == 0), 1'b0, "rnd_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
